// File: rtl/dpram_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dpram_reader                                                  |
// | Purpose  : Sweeps an address range through a DPRAM read port and streams |
// |            the words out over valid/ready, hiding the 1-cycle RAM read.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dpram_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] startaddr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rdaddr,
    input  logic [DATA_WIDTH-1:0] rddata,
    output logic                  outvalid,
    output logic [DATA_WIDTH-1:0] outdata,
    input  logic                  outready
);

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   c_REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic                  r_inflight;
    logic                  r_done;
    logic                  w_done_next;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;
    logic [1:0]            w_count_next;
    logic [2:0]            w_level;
    logic                  w_pop;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_last;

    assign w_pop        = (r_count != 2'd0) && outready;
    assign w_count_next = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    // Buffer occupancy plus pending capture after this cycle's pop; a new
    // read is only safe when that leaves room for one more word.
    assign w_level      = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_accept     = (r_state == S_IDLE) && start && !r_done;
    assign w_issue      = (r_state == S_READ) && (r_remaining != '0) && (w_level <= 3'd1);
    assign w_last       = (r_remaining == c_REM_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (len == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = S_READ;
                    end
                end
            end
            S_READ: begin
                if (w_issue && w_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_inflight && (w_count_next == 2'd0)) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
            r_buf0      <= '0;
            r_buf1      <= '0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            r_done     <= w_done_next;
            r_inflight <= w_issue;
            r_count    <= w_count_next;
            if (w_accept) begin
                r_addr      <= startaddr;
                r_remaining <= len;
            end else if (w_issue) begin
                r_addr      <= r_addr + c_ADDR_ONE;
                r_remaining <= r_remaining - c_REM_ONE;
            end
            // RAM data for last cycle's address is valid now
            if (r_inflight) begin
                if (r_wptr) begin
                    r_buf1 <= rddata;
                end else begin
                    r_buf0 <= rddata;
                end
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign rdaddr   = r_addr;
    assign outvalid = (r_count != 2'd0);
    assign outdata  = r_rptr ? r_buf1 : r_buf0;

endmodule
`default_nettype wire

// File: doc/dpram_reader.md
Name: dpram_reader

Overview:
- Single-clock read-side master for the dual-port RAM.
- On a start command, it sweeps a contiguous address range through the RAM read port and absorbs the RAM's one-cycle registered read latency.
- It presents the words in order on a valid/ready output stream, at one word per cycle when the stream never stalls.
- It lives in the read-clock domain; the write side fills the RAM independently.

Parameters:
- ADDR_WIDTH, 4, RAM address width. The RAM holds 2**ADDR_WIDTH words.
- DATA_WIDTH, 4, RAM and stream data width.

Ports:
- clk  input  1  posedge clock; drives the RAM read-port clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  start-command strobe; sampled only while idle.
- startaddr  input  ADDR_WIDTH  first address to read; sampled with start.
- len  input  ADDR_WIDTH+1  number of words to read, 0..2**ADDR_WIDTH; sampled with start.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse when a transfer completes.
- rdaddr  output  ADDR_WIDTH  RAM read address.
- rddata  input  DATA_WIDTH  RAM read data, valid the cycle after rdaddr is sampled.
- outvalid  output  1  stream data valid.
- outdata  output  DATA_WIDTH  stream data.
- outready  input  1  stream sink ready.

Behaviour:
- Reset, asynchronous and active-high: all state is cleared immediately.
  - busy=0, done=0, outvalid=0, outdata=0, rdaddr=0.
  - Output buffer emptied, in-flight flag cleared, state IDLE.
- Reset mid-transfer aborts the transfer with no done pulse. Data in flight is discarded.
- State machine IDLE -> READ -> DRAIN -> IDLE.
  - IDLE: start=1 latches startaddr into the address counter and len into the remaining counter.
    - len>0: go to READ.
    - len=0: done=1 for exactly one cycle in the next cycle; busy stays 0; no read is issued.
  - READ: busy=1. rdaddr is the registered address counter.
    - A read issues in any cycle where remaining>0 and (count + inflight - pop) <= 1.
      - count = output buffer occupancy, 0..2.
      - inflight = a read issued in the previous cycle.
      - pop = outvalid & outready.
    - On issue: the address counter increments modulo 2**ADDR_WIDTH (addresses wrap, e.g. 15 -> 0) and remaining decrements.
    - When the last read issues, go to DRAIN.
  - DRAIN: busy=1. When inflight=0 and count=0 (the last word has been accepted), go to IDLE.
    - In that IDLE cycle, done=1 for one cycle and busy=0.
- Read latency:
  - The RAM samples rdaddr at the edge ending the issue cycle.
  - rddata is captured into the output buffer at the edge ending the following cycle, when inflight=1.
  - Timing from start sampled at edge E0:
    - first rdaddr is presented in cycle 1;
    - outvalid first rises in cycle 3;
    - with outready held at 1, subsequent words follow every cycle.
- Output buffer: 2-entry FIFO, first in first out.
  - outdata is the head entry.
  - While outvalid=1 and outready=0, outvalid and outdata hold stable.
  - The buffer never overflows; the issue rule guarantees count+inflight <= 2.
  - A simultaneous capture and pop leave count unchanged.
- start while busy=1 or in the done cycle is ignored.
- Word order on the stream is strictly ascending address (with wrap). There are no duplicates and no drops under any outready pattern.
- Total beats on outvalid&outready equals the latched len.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> busy, done, outvalid, rdaddr read 0 immediately. Release, hold outready=1, no start -> outvalid stays 0.
- Basic: RAM preloaded with mem[i]=i; start, startaddr=2, len=4, outready=1 -> outvalid high in cycles 3..6 with outdata 2,3,4,5; done pulses in cycle 7; busy high cycles 1..6.
- Wrap and full length: startaddr=14, len=4 -> outdata 14,15,0,1. Then startaddr=0, len=16 -> all 16 words in order, back-to-back with outready=1.
- Backpressure: len=8, outready toggled 1,0,0,1,0,1,… ->
  - outdata holds stable whenever outready=0;
  - beats are 0..7 with none lost or repeated;
  - done pulses only after the 8th accepted beat.
- Zero length and ignored start: len=0 -> done pulses in cycle 1, busy and outvalid stay 0. During a len=4 transfer, pulse start with startaddr=9 -> ignored; the original sequence completes unchanged.
- Reset mid-operation: assert rst after 2 beats of len=8 -> outputs clear, no done. A fresh start with len=2 after release runs normally.
